// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, one outstanding imem request, output reg + 1-entry skid, redirect flush.
// Latency: grant in cycle N, rvalid in N+k -> instr_valid from N+k+1.
// Backpressure: stall holds instr outputs; imem_req drops while skid full. Option: FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redirect_tgt;
    logic        halt;
    logic        deliver;
    logic        consume;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_tgt = redirect_pc;
    assign halt         = fetch_misaligned;

    // Sticky until reset or an aligned redirect; while set no fetch is issued.
    always_ff @(posedge clk) begin
        if (reset)
            fetch_misaligned <= 1'b0;
        else if (redirect)
            fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
    end
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign halt                = 1'b0;
`endif

    assign imem_addr = pc;
    assign consume   = instr_valid & ~stall;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        imem_req  = 1'b0;
        deliver   = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~skid_valid & ~halt & ~reset;
                if (redirect) begin
                    pc_nxt = redirect_tgt;
                    if (imem_req & imem_gnt)
                        state_nxt = S_DROP;
                end else if (imem_req & imem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    if (redirect) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        deliver = 1'b1;
                        pc_nxt  = pc + 32'd4;
                    end
                end else if (redirect) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // The in-flight response belongs to the old path; only the PC follows redirects.
                if (redirect)
                    pc_nxt = redirect_tgt;
                if (imem_rvalid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            skid_valid  <= 1'b0;
            if (reset) begin
                instr_pc   <= 32'h0;
                skid_instr <= 32'h0;
                skid_pc    <= 32'h0;
            end
        end else if (consume && skid_valid) begin
            instr       <= skid_instr;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            // A word landing while the skid drains refills it immediately.
            if (deliver) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end else begin
                skid_valid <= 1'b0;
            end
        end else if (deliver && (!instr_valid || consume)) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (deliver) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
            skid_valid <= 1'b1;
        end else if (consume) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-based model of
// delivered words and a single-outstanding imem responder; second instance checks RESET_PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_req, imem_gnt, imem_rvalid, stall, redirect, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    logic        req2, valid2;
    logic        rv2 = 1'b0;
    logic [31:0] addr2, instr2, ipc2;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misaligned, mis2;
    bit          halted = 0;
`endif

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misaligned(fetch_misaligned)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
        .imem_rvalid(rv2), .imem_rdata(32'h0050_0093),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(valid2), .instr(instr2), .instr_pc(ipc2)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misaligned(mis2)
`endif
    );

    // Always-granting memory with one-cycle response for the wrap instance.
    always @(posedge clk) rv2 <= !reset && req2;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
    endfunction

    // Model: words delivered to decode but not yet consumed, next expected fetch address,
    // and the memory's single pending response.
    logic [31:0] q[$];
    logic [31:0] fetch_exp = 32'h0;
    bit          pend = 0, pend_stale = 0, pend_rst = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_lat = 0;
    int          gnt_pct = 100, lat_min = 0, lat_max = 0;
    int          consumed = 0;

    task automatic cyc();
        logic [31:0] tgt;
        bit          cons;
        #1;
        check("instr_valid", instr_valid, (q.size() > 0));
        if (q.size() > 0) begin
            check("instr_pc", instr_pc, q[0]);
            check("instr", instr, word_at(q[0]));
        end else begin
            check("instr_nop", instr, NOP);
        end
        if (reset)
            check("req_in_reset", imem_req, 0);
        else if (q.size() >= 2)
            check("req_skid_full", imem_req, 0);
        else if (pend && !pend_rst)
            check("req_outstanding", imem_req, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misaligned", fetch_misaligned, halted);
        if (halted && !reset)
            check("req_halted", imem_req, 0);
`endif
        imem_gnt    = imem_req && !pend && ($urandom_range(0, 99) < gnt_pct);
        imem_rvalid = pend && (pend_lat == 0);
        imem_rdata  = imem_rvalid ? word_at(pend_addr) : $urandom();
        if (imem_req && imem_gnt)
            check("imem_addr", imem_addr, fetch_exp);
        cons = (q.size() > 0) && !stall;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = redirect_pc;
`else
        tgt = redirect_pc & 32'hFFFF_FFFC;
`endif
        @(posedge clk);
        if (reset) begin
            q.delete();
            fetch_exp = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
            halted = 0;
`endif
        end else if (redirect) begin
            q.delete();
            fetch_exp = tgt;
`ifdef FETCH_MISALIGN_CHK_EN
            halted = (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (cons) begin
                void'(q.pop_front());
                consumed++;
            end
            if (imem_rvalid && !pend_stale) begin
                q.push_back(pend_addr);
                fetch_exp = fetch_exp + 32'd4;
            end
        end
        if (imem_rvalid) begin
            pend = 0;
        end else if (pend) begin
            pend_lat--;
            if (reset || redirect) pend_stale = 1;
            if (reset) pend_rst = 1;
        end
        if (imem_req && imem_gnt) begin
            pend       = 1;
            pend_addr  = imem_addr;
            pend_lat   = $urandom_range(lat_min, lat_max);
            pend_stale = redirect;
            pend_rst   = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        run(2);
        reset = 1'b0;
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, NOP);
        check("rst_pc", instr_pc, 32'h0);
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);

        // Immediate grant, 1-cycle response.
        run(2);
        check("wrap_next_addr", addr2, 32'h0);
        run(4);

        // Stall at a delivery: second word parks in the skid, requests stop.
        for (int i = 0; i < 20 && !instr_valid; i++) cyc();
        check("t2_have_instr", instr_valid, 1);
        stall = 1'b1;
        run(3);
        stall = 1'b0;
        run(6);

        // Redirect while waiting on a slow response.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !pend; i++) cyc();
        check("t3_reach_wait", pend, 1);
        redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        run(10);

        // Redirect coinciding with rvalid while decode stalls with a word held.
        lat_min = 1; lat_max = 1;
        stall = 1'b1;
        for (int i = 0; i < 30 && !(q.size() >= 1 && pend && pend_lat == 0); i++) cyc();
        check("t4_setup", (q.size() >= 1 && pend && pend_lat == 0), 1);
        redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        run(2);
        stall = 1'b0;
        run(8);

        // PC increment across the top of the address space.
        lat_min = 0; lat_max = 0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        run(6);

        // Reset while a response is outstanding.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !pend; i++) cyc();
        check("t6_reach_wait", pend, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run(12);

        // Misaligned redirect target.
        lat_min = 0; lat_max = 1;
        redirect = 1'b1; redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0;
        run(5);
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        run(6);

        // Random traffic.
        gnt_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0)
                redirect_pc = 32'hFFFF_FFF0 | {28'h0, redirect_pc[3:0]};
`ifdef FETCH_MISALIGN_CHK_EN
            redirect_pc[1:0] = 2'b00;
`endif
            reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        run(4);
        check("progress", (consumed > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
